mdu_iter: RTL

- Parametrised multiply/divide unit with architectural HI/LO, intended for use by the execute stage.
- Replaces the vendor divider IP cores with an in-house radix-2 restoring divider, and unifies MULT/MULTU/DIV/DIVU/MTHI/MTLO behind one valid/ready handshake.
- Supports pipeline flush (exception/eret). HI/LO commit only on result handshake, so cancelled ops never corrupt architectural state.

---
 rtl/mdu_iter.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// Multiply/divide unit with architectural HI/LO behind one valid/ready handshake.
// Define MDU_MUL_ITER_EN to replace the single-cycle multiplier with an iterative shift-add one.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             commit;
    logic [WIDTH-1:0] cur_hi;
    logic [WIDTH-1:0] cur_lo;

    logic             signed_op;
    logic             src1_neg;
    logic             src2_neg;
    logic [WIDTH-1:0] src1_mag;
    logic [WIDTH-1:0] src2_mag;

    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_nx;
    logic [WIDTH-1:0] div_quo_nx;
    logic [WIDTH-1:0] div_q_fix;
    logic [WIDTH-1:0] div_r_fix;

`ifdef MDU_MUL_ITER_EN
    logic               busy_mul;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_nx;
    logic [WIDTH-1:0]   mul_lo_nx;
    logic [2*WIDTH-1:0] mul_fix;
`else
    logic [2*WIDTH-1:0] mul_a;
    logic [2*WIDTH-1:0] mul_b;
    logic [2*WIDTH-1:0] mul_prod;
`endif

    assign in_ready  = !reset && !flush &&
                       ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign commit    = (state == S_DONE) && out_ready && !flush && !reset;
    assign out_valid = (state == S_DONE);

    // An op accepted in the same cycle as a commit must see the HI/LO being committed.
    assign cur_hi = commit ? out_hi : hi;
    assign cur_lo = commit ? out_lo : lo;

    always_comb begin
        signed_op = (in_op == OP_DIV) || (in_op == OP_MULT);
        src1_neg  = signed_op && in_src1[WIDTH-1];
        src2_neg  = signed_op && in_src2[WIDTH-1];
        src1_mag  = src1_neg ? -in_src1 : in_src1;
        src2_mag  = src2_neg ? -in_src2 : in_src2;
    end

    // Restoring divide step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    always_comb begin
        div_shift  = {acc_hi, acc_lo[WIDTH-1]};
        div_ge     = div_shift >= {1'b0, opnd};
        div_rem_nx = div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
        div_quo_nx = {acc_lo[WIDTH-2:0], div_ge};
        div_q_fix  = neg_q ? -div_quo_nx : div_quo_nx;
        div_r_fix  = neg_r ? -div_rem_nx : div_rem_nx;
    end

`ifdef MDU_MUL_ITER_EN
    // Shift-add multiply step: acc_lo holds the multiplier, the product shifts in from the top.
    always_comb begin
        mul_sum   = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opnd}) : {1'b0, acc_hi};
        mul_hi_nx = mul_sum[WIDTH:1];
        mul_lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};
        mul_fix   = neg_q ? -{mul_hi_nx, mul_lo_nx} : {mul_hi_nx, mul_lo_nx};
    end
`else
    always_comb begin
        mul_a    = (in_op == OP_MULT) ? {{WIDTH{in_src1[WIDTH-1]}}, in_src1}
                                      : {{WIDTH{1'b0}}, in_src1};
        mul_b    = (in_op == OP_MULT) ? {{WIDTH{in_src2[WIDTH-1]}}, in_src2}
                                      : {{WIDTH{1'b0}}, in_src2};
        mul_prod = mul_a * mul_b;
    end
`endif

    // Flush discards any pending result without touching HI/LO; otherwise commit and accept may coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            out_hi <= '0;
            out_lo <= '0;
            hi     <= '0;
            lo     <= '0;
`ifdef MDU_MUL_ITER_EN
            busy_mul <= 1'b0;
`endif
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            if (commit) begin
                hi <= out_hi;
                lo <= out_lo;
            end
            if (accept) begin
                cnt <= '0;
                case (in_op)
                    OP_DIV, OP_DIVU: begin
                        state  <= S_BUSY;
                        acc_hi <= '0;
                        acc_lo <= src1_mag;
                        opnd   <= src2_mag;
                        neg_q  <= src1_neg ^ src2_neg;
                        neg_r  <= src1_neg;
`ifdef MDU_MUL_ITER_EN
                        busy_mul <= 1'b0;
`endif
                    end
                    OP_MULT, OP_MULTU: begin
`ifdef MDU_MUL_ITER_EN
                        state    <= S_BUSY;
                        acc_hi   <= '0;
                        acc_lo   <= src2_mag;
                        opnd     <= src1_mag;
                        neg_q    <= src1_neg ^ src2_neg;
                        busy_mul <= 1'b1;
`else
                        state  <= S_DONE;
                        out_hi <= mul_prod[2*WIDTH-1:WIDTH];
                        out_lo <= mul_prod[WIDTH-1:0];
`endif
                    end
                    OP_MTHI: begin
                        state  <= S_DONE;
                        out_hi <= in_src1;
                        out_lo <= cur_lo;
                    end
                    OP_MTLO: begin
                        state  <= S_DONE;
                        out_hi <= cur_hi;
                        out_lo <= in_src1;
                    end
                    default: begin
                        state  <= S_DONE;
                        out_hi <= cur_hi;
                        out_lo <= cur_lo;
                    end
                endcase
            end else if (commit) begin
                state <= S_IDLE;
            end else if (state == S_BUSY) begin
                cnt <= cnt + CNT_W'(1);
`ifdef MDU_MUL_ITER_EN
                if (busy_mul) begin
                    acc_hi <= mul_hi_nx;
                    acc_lo <= mul_lo_nx;
                    if (cnt == LAST_ITER) begin
                        state  <= S_DONE;
                        out_hi <= mul_fix[2*WIDTH-1:WIDTH];
                        out_lo <= mul_fix[WIDTH-1:0];
                    end
                end else begin
`else
                begin
`endif
                    acc_hi <= div_rem_nx;
                    acc_lo <= div_quo_nx;
                    if (cnt == LAST_ITER) begin
                        state  <= S_DONE;
                        out_hi <= div_r_fix;
                        out_lo <= div_q_fix;
                    end
                end
            end
        end
    end

endmodule
